// File: rtl/perceptron_trainer.sv
// Training sequencer for the single-layer perceptron: walks the sample RAM once per epoch,
// issues one train step per sample and stops on an error-free epoch or the epoch limit.
module perceptron_trainer #(
    parameter int N      = 8,
    parameter int ADDR_W = 4,
    parameter int LAT    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W:0]   i_num_samples,
    input  logic [15:0]       i_max_epochs,
    input  logic [31:0]       i_learning_rate,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [N-2:0]      i_mem_x,
    input  logic [31:0]       i_mem_y,
    output logic [N-2:0]      o_p_x,
    output logic [31:0]       o_p_expected_y,
    output logic [31:0]       o_p_learning_rate,
    output logic              o_p_train,
    input  logic [31:0]       i_p_y,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_converged,
    output logic [15:0]       o_epoch_count,
    output logic [ADDR_W:0]   o_error_count
);

    localparam int HW = (LAT < 2) ? 1 : $clog2(LAT + 1);
    localparam logic [HW-1:0]     HOLD_INIT = HW'(LAT);
    localparam logic [HW-1:0]     HOLD_ONE  = HW'(1);
    localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_HOLD,
        S_EPOCH_END,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_num;
    logic [15:0]       r_max_ep;
    logic [ADDR_W-1:0] r_addr;
    logic [HW-1:0]     r_hold;
    logic              r_mem_rd;
    logic [N-2:0]      r_p_x;
    logic [31:0]       r_p_ey;
    logic [31:0]       r_p_lr;
    logic              r_p_train;
    logic              r_busy;
    logic              r_done;
    logic              r_conv;
    logic [15:0]       r_epoch;
    logic [ADDR_W:0]   r_err;

    logic              w_last_sample;
    logic              w_mismatch;
    logic [15:0]       w_epoch_next;

    assign w_last_sample = ({1'b0, r_addr} == (r_num - CNT_ONE));
    assign w_mismatch    = (i_p_y != r_p_ey);
    assign w_epoch_next  = r_epoch + 16'd1;

    // done is registered out of DONE, so it is seen the cycle after the FSM passes through DONE
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_num     <= '0;
            r_max_ep  <= '0;
            r_addr    <= '0;
            r_hold    <= '0;
            r_mem_rd  <= 1'b0;
            r_p_x     <= '0;
            r_p_ey    <= '0;
            r_p_lr    <= '0;
            r_p_train <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_conv    <= 1'b0;
            r_epoch   <= '0;
            r_err     <= '0;
        end else if (i_abort) begin
            r_state   <= S_IDLE;
            r_mem_rd  <= 1'b0;
            r_p_train <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_p_lr    <= '0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_p_train <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num    <= i_num_samples;
                        r_max_ep <= i_max_epochs;
                        r_p_lr   <= i_learning_rate;
                        r_conv   <= 1'b0;
                        r_epoch  <= '0;
                        r_err    <= '0;
                        r_addr   <= '0;
                        if (i_num_samples == '0 || i_max_epochs == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state  <= S_FETCH;
                            r_mem_rd <= 1'b1;
                            r_busy   <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_p_x     <= i_mem_x;
                    r_p_ey    <= i_mem_y;
                    r_p_train <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_mismatch && r_err != ERR_MAX) begin
                        r_err <= r_err + CNT_ONE;
                    end
                    r_hold  <= HOLD_INIT;
                    r_state <= S_HOLD;
                end
                // Inputs stay frozen here until the update has left the perceptron pipeline
                S_HOLD: begin
                    if (r_hold == HOLD_ONE) begin
                        if (w_last_sample) begin
                            r_state <= S_EPOCH_END;
                        end else begin
                            r_addr   <= r_addr + ADDR_ONE;
                            r_mem_rd <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end else begin
                        r_hold <= r_hold - HOLD_ONE;
                    end
                end
                S_EPOCH_END: begin
                    r_epoch <= w_epoch_next;
                    if (r_err == '0) begin
                        r_conv  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else if (w_epoch_next == r_max_ep) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_err    <= '0;
                        r_addr   <= '0;
                        r_mem_rd <= 1'b1;
                        r_state  <= S_FETCH;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_p_lr  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_rd          = r_mem_rd;
    assign o_mem_addr        = r_addr;
    assign o_p_x             = r_p_x;
    assign o_p_expected_y    = r_p_ey;
    assign o_p_learning_rate = r_p_lr;
    assign o_p_train         = r_p_train;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_converged       = r_conv;
    assign o_epoch_count     = r_epoch;
    assign o_error_count     = r_err;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: a stimulus process queues the expected RAM reads and
// run results from an epoch-level reference model; a monitor pops and compares as the DUT responds.
module tb_perceptron_trainer;

    localparam int N      = 8;
    localparam int ADDR_W = 4;
    localparam int LAT    = 3;
    localparam int XW     = N - 1;

    typedef struct {
        int conv;
        int epochs;
        int errs;
        int trains;
        int trainsBase;
        int doneAt;
    } result_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              startIn = 1'b0;
    logic              abortIn = 1'b0;
    logic [ADDR_W:0]   numIn = '0;
    logic [15:0]       maxIn = '0;
    logic [31:0]       rateIn = '0;
    logic              memRd;
    logic [ADDR_W-1:0] memAddr;
    logic [XW-1:0]     memX = '0;
    logic [31:0]       memY = '0;
    logic [XW-1:0]     pX;
    logic [31:0]       pEy;
    logic [31:0]       pLr;
    logic              pTrain;
    logic [31:0]       pY;
    logic              busy;
    logic              done;
    logic              converged;
    logic [15:0]       epochCount;
    logic [ADDR_W:0]   errorCount;

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int totalTrains = 0;
    logic [31:0] curRate = '0;

    logic [XW-1:0] ramX [16];
    logic [31:0]   ramY [16];
    int            wrongInit [16];
    int            wrongLeft [16];
    logic          modelLoad = 1'b0;
    logic [LAT-1:0] pipeV = '0;
    logic [3:0]    pipeIdx [LAT];

    int      addrQ [$];
    result_t resultQ [$];

    perceptron_trainer #(.N(N), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .i_clk             (clock),
        .i_rst             (reset),
        .i_start           (startIn),
        .i_abort           (abortIn),
        .i_num_samples     (numIn),
        .i_max_epochs      (maxIn),
        .i_learning_rate   (rateIn),
        .o_mem_rd          (memRd),
        .o_mem_addr        (memAddr),
        .i_mem_x           (memX),
        .i_mem_y           (memY),
        .o_p_x             (pX),
        .o_p_expected_y    (pEy),
        .o_p_learning_rate (pLr),
        .o_p_train         (pTrain),
        .i_p_y             (pY),
        .o_busy            (busy),
        .o_done            (done),
        .o_converged       (converged),
        .o_epoch_count     (epochCount),
        .o_error_count     (errorCount)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Synchronous sample RAM; outside a read the data bus carries junk so held inputs are exercised
    always @(posedge clock) begin
        if (memRd) begin
            memX <= ramX[memAddr];
            memY <= ramY[memAddr];
        end else begin
            memX <= XW'($urandom);
            memY <= $urandom;
        end
    end

    // Perceptron stand-in: a sample answers wrongly until it has been trained wrongLeft times,
    // and each training step takes effect LAT cycles after the train pulse
    always @(posedge clock) begin
        if (modelLoad) begin
            wrongLeft <= wrongInit;
            pipeV <= '0;
        end else begin
            pipeV <= {pipeV[LAT-2:0], pTrain};
            pipeIdx[0] <= pX[3:0];
            for (int k = 1; k < LAT; k++) pipeIdx[k] <= pipeIdx[k-1];
            if (pipeV[LAT-1] && wrongLeft[pipeIdx[LAT-1]] > 0)
                wrongLeft[pipeIdx[LAT-1]] <= wrongLeft[pipeIdx[LAT-1]] - 1;
        end
    end

    assign pY = (wrongLeft[pX[3:0]] != 0) ? ~pEy : pEy;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Epoch-level view of training: every sample is visited once per epoch, a wrong answer counts
    // as an error and trains that sample once
    function automatic void refRun(input int num, input int maxE, input int wr [16],
                                   output int conv, output int epochs, output int errs, output int trains);
        int w [16];
        w = wr;
        conv = 0;
        epochs = 0;
        errs = 0;
        trains = 0;
        if (num == 0 || maxE == 0) return;
        for (int e = 0; e < maxE; e++) begin
            errs = 0;
            for (int i = 0; i < num; i++) begin
                trains++;
                if (w[i] > 0) begin
                    errs++;
                    w[i]--;
                end
            end
            epochs++;
            if (errs == 0) begin
                conv = 1;
                break;
            end
        end
        if (errs > 16) errs = 16;
    endfunction

    // Monitor: pops expectations whenever the DUT reads RAM, trains, or signals done
    int  lastAddr = 0;
    int  prevTrain = 0;
    bit  havePrev = 0;
    int  holdLeft = 0;
    logic [XW-1:0] holdX = '0;
    logic [31:0]   holdY = '0;
    always @(negedge clock) begin
        result_t r;
        if (memRd) begin
            if (addrQ.size() == 0) checkOutput("unexpected mem_rd", {31'd0, memRd}, 32'd0);
            else begin
                lastAddr = addrQ.pop_front();
                checkOutput("mem_addr", {28'd0, memAddr}, lastAddr);
            end
        end
        if (!busy) begin
            havePrev = 0;
            holdLeft = 0;
        end
        if (pTrain) begin
            totalTrains++;
            if (havePrev)
                checkOutput("train spacing", {31'd0, (cycle - prevTrain >= LAT + 3) && (cycle - prevTrain <= LAT + 4)}, 32'd1);
            havePrev = 1;
            prevTrain = cycle;
            checkOutput("p_x at train", {25'd0, pX}, {25'd0, ramX[lastAddr]});
            checkOutput("p_expected_y at train", pEy, ramY[lastAddr]);
            checkOutput("p_learning_rate", pLr, curRate);
            holdLeft = LAT;
            holdX = pX;
            holdY = pEy;
        end else if (holdLeft > 0) begin
            checkOutput("p_x held", {25'd0, pX}, {25'd0, holdX});
            checkOutput("p_expected_y held", pEy, holdY);
            holdLeft--;
        end
        if (done) begin
            if (resultQ.size() == 0) checkOutput("unexpected done", {31'd0, done}, 32'd0);
            else begin
                r = resultQ.pop_front();
                checkOutput("done cycle", cycle, r.doneAt);
                checkOutput("converged", {31'd0, converged}, r.conv);
                checkOutput("epoch_count", {16'd0, epochCount}, r.epochs);
                checkOutput("error_count", {27'd0, errorCount}, r.errs);
                checkOutput("train pulses", totalTrains - r.trainsBase, r.trains);
                checkOutput("busy at done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_rd"}, {31'd0, memRd}, 32'd0);
        checkOutput({tag, " mem_addr"}, {28'd0, memAddr}, 32'd0);
        checkOutput({tag, " p_x"}, {25'd0, pX}, 32'd0);
        checkOutput({tag, " p_expected_y"}, pEy, 32'd0);
        checkOutput({tag, " p_learning_rate"}, pLr, 32'd0);
        checkOutput({tag, " p_train"}, {31'd0, pTrain}, 32'd0);
        checkOutput({tag, " busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, " converged"}, {31'd0, converged}, 32'd0);
        checkOutput({tag, " epoch_count"}, {16'd0, epochCount}, 32'd0);
        checkOutput({tag, " error_count"}, {27'd0, errorCount}, 32'd0);
    endtask

    // mode 0: always right, 1: always wrong, 2: each sample wrong 0..3 times.
    // stopAfter > 0 queues only that many RAM reads and leaves the run for the caller to cut short.
    task automatic applyStimulus(input int num, input int maxE, input int mode, input bit busyStart, input int stopAfter);
        int conv, epochs, errs, trains, lat, s;
        result_t r;
        curRate = $urandom;
        for (int a = 0; a < 16; a++) begin
            ramX[a] = XW'(int'($urandom_range(0, 7)) * 16 + a);
            ramY[a] = $urandom;
            wrongInit[a] = (mode == 0) ? 0 : ((mode == 1) ? 255 : int'($urandom_range(0, 3)));
        end
        refRun(num, maxE, wrongInit, conv, epochs, errs, trains);
        @(negedge clock) modelLoad = 1'b1;
        @(negedge clock) modelLoad = 1'b0;
        if (stopAfter == 0) begin
            for (int e = 0; e < epochs; e++)
                for (int i = 0; i < num; i++) addrQ.push_back(i);
        end else begin
            for (int i = 0; i < stopAfter; i++) addrQ.push_back(i);
        end
        lat = (num == 0 || maxE == 0) ? 2 : epochs * (num * (LAT + 3) + 1) + 2;
        numIn = (ADDR_W+1)'(num);
        maxIn = 16'(maxE);
        rateIn = curRate;
        startIn = 1'b1;
        s = cycle;
        if (stopAfter == 0) begin
            r = '{conv, epochs, errs, trains, totalTrains, s + lat};
            resultQ.push_back(r);
        end
        @(negedge clock);
        startIn = 1'b0;
        numIn = (ADDR_W+1)'($urandom);
        maxIn = 16'($urandom);
        rateIn = $urandom;
        if (busyStart) begin
            repeat (8) @(negedge clock);
            startIn = 1'b1;
            @(negedge clock);
            startIn = 1'b0;
        end
        if (stopAfter == 0) begin
            for (int k = 0; k < lat + 20 && resultQ.size() != 0; k++) @(negedge clock);
            checkOutput("run completed", resultQ.size(), 32'd0);
            resultQ.delete();
            addrQ.delete();
            repeat (3) @(negedge clock);
        end
    endtask

    initial begin
        int trainsSeen;
        int expErr;
        bit sawDone;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkAllZero("reset");

        // Converges in one epoch, always-wrong epoch limit, degenerate sizes
        applyStimulus(4, 10, 0, 0, 0);
        applyStimulus(3, 2, 1, 0, 0);
        applyStimulus(0, 5, 0, 0, 0);
        applyStimulus(4, 0, 0, 0, 0);

        // Abort in the first HOLD cycle of sample 2
        applyStimulus(4, 10, 1, 0, 3);
        expErr = 0;
        for (int a = 0; a < 3; a++) if (wrongInit[a] > 0) expErr++;
        trainsSeen = 0;
        for (int k = 0; k < 100 && trainsSeen < 3; k++) begin
            @(negedge clock);
            if (pTrain) trainsSeen++;
        end
        checkOutput("abort reached sample 2", trainsSeen, 32'd3);
        @(negedge clock) abortIn = 1'b1;
        @(negedge clock) abortIn = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort p_train", {31'd0, pTrain}, 32'd0);
        checkOutput("abort done", {31'd0, done}, 32'd0);
        checkOutput("abort p_learning_rate", pLr, 32'd0);
        checkOutput("abort error_count frozen", {27'd0, errorCount}, expErr);
        checkOutput("abort epoch_count frozen", {16'd0, epochCount}, 32'd0);
        sawDone = 0;
        repeat (12) begin
            @(negedge clock);
            sawDone |= done;
        end
        checkOutput("no done after abort", {31'd0, sawDone}, 32'd0);
        addrQ.delete();

        // Largest training set, always wrong: error_count reaches its ceiling; start while busy ignored
        applyStimulus(16, 1, 1, 1, 0);

        // Reset asserted in ISSUE of the first sample
        applyStimulus(3, 5, 2, 0, 1);
        trainsSeen = 0;
        for (int k = 0; k < 20 && trainsSeen < 1; k++) begin
            @(negedge clock);
            if (pTrain) trainsSeen++;
        end
        checkOutput("reached ISSUE before reset", trainsSeen, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkAllZero("mid-run reset");
        addrQ.delete();
        repeat (3) @(negedge clock);
        applyStimulus(5, 4, 2, 0, 0);

        for (int t = 0; t < 6; t++) begin
            int num;
            num = int'($urandom_range(1, 16));
            applyStimulus(num, int'($urandom_range(1, 5)), int'($urandom_range(0, 2)),
                          (num >= 3) && ($urandom_range(0, 1) == 1), 0);
        end

        checkOutput("address queue drained", addrQ.size(), 32'd0);
        checkOutput("result queue drained", resultQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training sequencer for the single-layer perceptron. It steps through a training set held in an external synchronous sample RAM, one sample at a time. For each sample it drives the perceptron's x, expected_y, learning_rate and train inputs, and holds them stable until the weight update has passed the perceptron's input delay pipeline. It counts misclassifications per epoch and stops when an epoch has zero errors or when an epoch limit is reached.

## Interface
Parameters:
- N, 8: perceptron size; the sample vector is N-1 bits wide (bits N-1:1).
- ADDR_W, 4: sample RAM address width; the training set holds at most 2^ADDR_W samples.
- LAT, 3: cycles from p_train assertion until the perceptron applies the weight update. This equals its register stage count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins training; ignored while busy.
- abort  in  1  returns the block to IDLE on the next edge.
- num_samples  in  ADDR_W+1  training set size, 0..2^ADDR_W; sampled at start.
- max_epochs  in  16  epoch limit; sampled at start.
- learning_rate  in  32  fixed-point rate; sampled at start.
- mem_rd  out  1  sample RAM read strobe.
- mem_addr  out  ADDR_W  sample RAM address.
- mem_x  in  N-1  sample vector; valid the cycle after mem_rd.
- mem_y  in  32  expected output; valid the cycle after mem_rd.
- p_x  out  N-1  to perceptron x.
- p_expected_y  out  32  to perceptron expected_y.
- p_learning_rate  out  32  to perceptron learning_rate.
- p_train  out  1  to perceptron train.
- p_y  in  32  perceptron output y (combinational on the current weights and p_x).
- busy  out  1  high from the cycle after accepted start until DONE.
- done  out  1  one-cycle pulse at completion.
- converged  out  1  last run ended on a zero-error epoch.
- epoch_count  out  16  epochs completed in the current or last run.
- error_count  out  ADDR_W+1  misclassifications in the current or last epoch.

## Operation
States are IDLE, FETCH, LOAD, ISSUE, HOLD, EPOCH_END and DONE.

- **IDLE.** On start:
  - Latch num_samples, max_epochs and learning_rate.
  - Clear converged, epoch_count and error_count; set addr to 0.
  - If num_samples==0 or max_epochs==0, go to DONE with converged=0.
  - Otherwise go to FETCH.
- **FETCH.** Assert mem_rd=1 with mem_addr=addr, then go to LOAD.
- **LOAD.** Register p_x=mem_x and p_expected_y=mem_y, then go to ISSUE.
- **ISSUE.** This state lasts exactly one cycle.
  - Assert p_train=1.
  - Compare p_y with p_expected_y using full 32-bit equality. On mismatch, error_count increments (saturating at 2^ADDR_W).
  - Go to HOLD with the hold counter set to LAT.
- **HOLD.** p_train=0. p_x, p_expected_y and p_learning_rate are held unchanged.
  - The hold counter decrements each cycle.
  - When it reaches 1, either increment addr and go to FETCH, or go to EPOCH_END if addr==num_samples-1.
- **EPOCH_END.** This state lasts one cycle. epoch_count increments.
  - If error_count==0: set converged=1 and go to DONE.
  - Else if the new epoch_count==max_epochs: go to DONE with converged=0.
  - Otherwise clear error_count, set addr=0 and go to FETCH.
- **DONE.** done=1 for one cycle, busy=0, then go to IDLE.
  - converged, epoch_count and error_count hold until the next accepted start.
- **Output drive.** p_learning_rate is driven from the latched rate throughout the run and is 0 in IDLE. p_train is asserted only in ISSUE.

## Timing
- **Reset values.** All outputs are 0, state is IDLE and addr is 0.
- **start.** Accepted only in IDLE. A start in any other state, including DONE, is ignored.
- **Per-sample cost.** FETCH(1) + LOAD(1) + ISSUE(1) + HOLD(LAT) = LAT+3 cycles; 6 cycles at the default.
- **Per-epoch cost.** num_samples*(LAT+3)+1 cycles.
- **No overlap between samples.** The next sample's p_train rises no earlier than LAT+3 cycles after the previous one. This guarantees the previous update has been applied before p_y is evaluated.
- **Start to first train pulse.** start accepted at cycle 0 → FETCH at 1, LOAD at 2, p_train=1 at 3.
- **Zero-count start.** done rises 2 cycles after start.
- **abort.** Takes effect on the next edge in any state. The block goes to IDLE, with p_train=0, busy=0 and done=0. Counters freeze at their current values.
  - If a train pulse is still in the perceptron pipeline, it completes normally.
  - When abort and start are asserted in the same cycle in IDLE, abort wins.
- **rst mid-run.** Behaves like abort, and additionally clears all registers.
- **Wrap-around.** epoch_count cannot wrap, because the limit is at most 65535. error_count saturates.

## Test plan
- **Convergence on first epoch.**
  - Stimulus: rst, then start with num_samples=4, max_epochs=10, and a perceptron model whose p_y always equals mem_y.
  - Required response: exactly 4 p_train pulses spaced 6 cycles apart, done at cycle 3+4*6, converged=1, epoch_count=1, error_count=0.
- **Epoch limit.**
  - Stimulus: a model that always mismatches, with num_samples=3 and max_epochs=2.
  - Required response: 6 train pulses, converged=0, epoch_count=2, error_count=3.
- **Degenerate sizes.**
  - Stimulus: start with num_samples=0; then start with max_epochs=0.
  - Required response in both cases: no mem_rd, no p_train, done 2 cycles after start, converged=0, epoch_count=0.
- **Input stability.**
  - Stimulus: mem_x changes every cycle while HOLD is in progress.
  - Required response: p_x and p_expected_y are constant from LOAD through the end of HOLD. mem_addr sequence is 0,1,2,...,num_samples-1 and then repeats per epoch.
- **abort / start collisions.**
  - Stimulus: abort during HOLD of sample 2; later, start asserted during busy.
  - Required response: abort gives IDLE on the next edge with p_train=0 and no done pulse. The start during busy is ignored, with no restart and no counter clear.
- **Mid-run reset.**
  - Stimulus: assert rst in ISSUE.
  - Required response: the next cycle has all outputs 0. A subsequent start runs a normal sequence from addr 0.
